mix_columns_stage: RTL and testbench

// - Downstream consumer of the byte-wide masked S-box (SubBytes) output in the modified AES-256 datapath.
// - Collects 16 substituted bytes serially, then applies ShiftRows followed by MixColumns.
// - Presents the finished 128-bit round state, which feeds AddRoundKey.
// - Valid/ready handshake on both sides, single-entry output buffer.

---
 rtl/mix_columns_stage.sv | 159 +++++++++++++++
 tb/tb_mix_columns_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_stage.sv
// mix_columns_stage
// Collects 16 SubBytes output bytes one at a time, then applies ShiftRows
// and MixColumns and presents the 128-bit round state to AddRoundKey.
// Bytes arrive in column-major order: idx = row + 4*col.
//
// Parameters
//   POLY      xtime reduction constant (low byte of the GF(2^8) modulus)
//   SWAP_OUT  0: state byte 0 at m_data[127:120]; 1: state byte 0 at m_data[7:0]
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   s_byte[7:0]  input byte
//   s_valid      s_byte valid
//   s_ready      stage accepts a byte (FILL only, low during and just after reset)
//   s_flush      drop a partially filled state (FILL only)
//   m_data[127:0] ShiftRows+MixColumns result, registered
//   m_valid      m_data valid, held until m_ready
//   m_ready      downstream accepts m_data
//   busy         byte count nonzero or m_valid high
//   final_round  (only with MIXCOL_FINAL_ROUND_EN) sampled with byte 15;
//                1 skips MixColumns for this block
//
// Build option: define MIXCOL_FINAL_ROUND_EN to add the final_round port.
//
// state | meaning
// FILL  | accepting bytes into sbuf[cnt]
// CALC  | one cycle: register SR/MC result into m_data
// HOLD  | m_valid high, waiting for m_ready

module mix_columns_stage #(
  parameter logic [7:0] POLY     = 8'h1B,
  parameter bit         SWAP_OUT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   s_byte,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_flush,
  output logic [127:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
`ifdef MIXCOL_FINAL_ROUND_EN
  input  logic         final_round,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [7:0]   sbuf [16];
  logic [3:0]   cnt_q;
  logic         alive_q;   // keeps s_ready low until the first edge after reset release
  logic         accept;
  logic [127:0] result;

`ifdef MIXCOL_FINAL_ROUND_EN
  logic         final_q;
`endif

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? POLY : 8'h00);
  endfunction

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // FSM: next state and handshake outputs
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      FILL: begin
        s_ready = alive_q;
        // flush wins over a simultaneous byte
        accept  = s_valid & alive_q & ~s_flush;
        if (accept && cnt_q == 4'd15) state_d = CALC;
      end
      CALC: state_d = HOLD;
      HOLD: if (m_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Byte collection and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q <= 1'b0;
      cnt_q   <= 4'd0;
      m_data  <= '0;
      m_valid <= 1'b0;
      for (int i = 0; i < 16; i++) sbuf[i] <= 8'h00;
`ifdef MIXCOL_FINAL_ROUND_EN
      final_q <= 1'b0;
`endif
    end else begin
      alive_q <= 1'b1;
      if (state_q == FILL && s_flush) begin
        cnt_q <= 4'd0;
      end else if (accept) begin
        sbuf[cnt_q] <= s_byte;
        cnt_q       <= cnt_q + 4'd1;   // wraps 15 -> 0 on the last byte
`ifdef MIXCOL_FINAL_ROUND_EN
        if (cnt_q == 4'd15) final_q <= final_round;
`endif
      end
      if (state_q == CALC) begin
        m_data  <= result;
        m_valid <= 1'b1;
      end else if (state_q == HOLD && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign busy = (cnt_q != 4'd0) | m_valid;

  // ShiftRows folded into the column gather: output column c, row r comes
  // from input column (c+r) mod 4, same row.
  logic [7:0] a0, a1, a2, a3;
  logic [7:0] o0, o1, o2, o3;

  always_comb begin
    result = '0;
    a0 = 8'h00; a1 = 8'h00; a2 = 8'h00; a3 = 8'h00;
    o0 = 8'h00; o1 = 8'h00; o2 = 8'h00; o3 = 8'h00;
    for (int c = 0; c < 4; c++) begin
      a0 = sbuf[4'(0 + 4 * c)];
      a1 = sbuf[4'(1 + 4 * ((c + 1) % 4))];
      a2 = sbuf[4'(2 + 4 * ((c + 2) % 4))];
      a3 = sbuf[4'(3 + 4 * ((c + 3) % 4))];
      o0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
`ifdef MIXCOL_FINAL_ROUND_EN
      if (final_q) begin
        o0 = a0; o1 = a1; o2 = a2; o3 = a3;
      end
`endif
      if (SWAP_OUT) begin
        result[32 * c +: 32] = {o3, o2, o1, o0};
      end else begin
        result[96 - 32 * c +: 32] = {o0, o1, o2, o3};
      end
    end
  end

endmodule

// File: tb/tb_mix_columns_stage.sv
module tb_mix_columns_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   s_byte;
  logic         s_valid;
  logic         s_ready;
  logic         s_flush;
  logic [127:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         busy;
`ifdef MIXCOL_FINAL_ROUND_EN
  logic         final_round;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mix_columns_stage dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_byte  (s_byte),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_flush (s_flush),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
`ifdef MIXCOL_FINAL_ROUND_EN
    .final_round (final_round),
`endif
    .busy    (busy)
  );

  typedef struct {
    logic [7:0]  col [4];
    logic [31:0] exp_col;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: GF(2^8) multiply by shift-and-add, matrix form of MixColumns.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_block(input logic [7:0] b [16], input bit fr);
    logic [7:0]   st [4][4];
    logic [7:0]   sh [4][4];
    logic [7:0]   mx [4][4];
    logic [7:0]   coef [4];
    logic [127:0] o = '0;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) st[r][c] = b[r + 4 * c];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) sh[r][c] = st[r][(c + r) % 4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mx[r][c] = 8'h00;
        for (int k = 0; k < 4; k++) mx[r][c] ^= gmul(coef[(k - r + 4) % 4], sh[k][c]);
        if (fr) mx[r][c] = sh[r][c];
      end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[127 - 8 * (r + 4 * c) -: 8] = mx[r][c];
    return o;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_byte  = b;
    s_valid = 1'b1;
    while (!s_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("s_ready_timeout", {127'd0, s_ready}, 128'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  // Sends 16 bytes with optional idle gaps, then checks the one-cycle CALC latency.
  task automatic send_block(input logic [7:0] b [16], input int gap_max, input bit fr);
`ifdef MIXCOL_FINAL_ROUND_EN
    final_round = fr;
`endif
    for (int i = 0; i < 16; i++) begin
      if (gap_max > 0) begin
        m_ready = 1'($urandom_range(0, 1));   // ignored while m_valid=0
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk); #1;
        end
      end
      send_byte(b[i]);
    end
    m_ready = 1'b0;
`ifdef MIXCOL_FINAL_ROUND_EN
    final_round = ~fr;   // don't-care after byte 15
`endif
    chk("calc_cycle_m_valid", {127'd0, m_valid}, 128'd0);
    chk("calc_cycle_s_ready", {127'd0, s_ready}, 128'd0);
    @(posedge clk); #1;
    chk("latency_m_valid", {127'd0, m_valid}, 128'd1);
  endtask

  // Waits for m_valid, stalls for hold cycles (with ignored s_valid/s_flush), then accepts.
  task automatic finish_block(input logic [127:0] exp, input int hold);
    int n = 0;
    while (!m_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("m_valid_timeout", {127'd0, m_valid}, 128'd1);
    chk("m_data", m_data, exp);
    s_byte = 8'hEE;
    for (int i = 0; i < hold; i++) begin
      s_valid = 1'b1;
      s_flush = 1'(i & 1);
      @(posedge clk); #1;
      chk("hold_m_data", m_data, exp);
      chk("hold_m_valid", {127'd0, m_valid}, 128'd1);
      chk("hold_s_ready", {127'd0, s_ready}, 128'd0);
    end
    s_valid = 1'b0;
    s_flush = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("after_accept_m_valid", {127'd0, m_valid}, 128'd0);
    chk("after_accept_s_ready", {127'd0, s_ready}, 128'd1);
    chk("after_accept_busy", {127'd0, busy}, 128'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_m_valid", {127'd0, m_valid}, 128'd0);
    chk("rst_m_data", m_data, 128'd0);
    chk("rst_s_ready", {127'd0, s_ready}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rel_s_ready_low", {127'd0, s_ready}, 128'd0);
    @(posedge clk); #1;
    chk("rel_s_ready_high", {127'd0, s_ready}, 128'd1);
  endtask

  initial begin
    vec_t        vecs [6];
    logic [7:0]  blk [16];
    logic [7:0]  ones [16];
    logic [127:0] exp;
    bit          fr;

    vecs[0] = '{col: '{8'hdb, 8'h13, 8'h53, 8'h45}, exp_col: 32'h8e4da1bc};
    vecs[1] = '{col: '{8'hf2, 8'h0a, 8'h22, 8'h5c}, exp_col: 32'h9fdc589d};
    vecs[2] = '{col: '{8'h01, 8'h01, 8'h01, 8'h01}, exp_col: 32'h01010101};
    vecs[3] = '{col: '{8'hc6, 8'hc6, 8'hc6, 8'hc6}, exp_col: 32'hc6c6c6c6};
    vecs[4] = '{col: '{8'hd4, 8'hd4, 8'hd4, 8'hd5}, exp_col: 32'hd5d5d7d6};
    vecs[5] = '{col: '{8'h2d, 8'h26, 8'h31, 8'h4c}, exp_col: 32'h4d7ebdf8};

    for (int i = 0; i < 16; i++) ones[i] = 8'h01;

    s_byte = 8'h00; s_valid = 1'b0; s_flush = 1'b0; m_ready = 1'b0;
`ifdef MIXCOL_FINAL_ROUND_EN
    final_round = 1'b0;
`endif
    rst_n = 1'b1;
    #2;
    do_reset();

    // all-0x01 block, back to back
    send_block(ones, 0, 1'b0);
    finish_block({16{8'h01}}, 0);

    // table vectors: every column identical, so ShiftRows is transparent
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 16; i++) blk[i] = vecs[v].col[i % 4];
      send_block(blk, 0, 1'b0);
      finish_block({4{vecs[v].exp_col}}, (v == 1) ? 5 : 1);
    end

    // partial fill, flush together with an 8th byte, then a clean block
    for (int i = 0; i < 7; i++) send_byte(8'hA0 + 8'(i));
    chk("busy_partial", {127'd0, busy}, 128'd1);
    s_byte = 8'h55; s_valid = 1'b1; s_flush = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_flush = 1'b0;
    chk("busy_after_flush", {127'd0, busy}, 128'd0);
    send_block(ones, 0, 1'b0);
    finish_block({16{8'h01}}, 2);

`ifdef MIXCOL_FINAL_ROUND_EN
    for (int i = 0; i < 16; i++) blk[i] = 8'(i);
    send_block(blk, 0, 1'b1);
    finish_block(128'h00050a0f_04090e03_080d0207_0c01060b, 0);
`endif

    // reset while holding an output
    for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
    send_block(blk, 0, 1'b0);
    do_reset();
    for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
    send_block(blk, 0, 1'b0);
    finish_block(ref_block(blk, 1'b0), 0);

    // reset mid-fill
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    do_reset();
    for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
    send_block(blk, 0, 1'b0);
    finish_block(ref_block(blk, 1'b0), 1);

    // randomized blocks with gaps and stalls
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
`ifdef MIXCOL_FINAL_ROUND_EN
      fr = 1'($urandom_range(0, 1));
`else
      fr = 1'b0;
`endif
      exp = ref_block(blk, fr);
      send_block(blk, 2, fr);
      finish_block(exp, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
